// File: rtl/exu_stage.sv
// Execute stage: RV32 integer ALU with a registered result, a one-entry skid buffer,
// a pipeline flush and a counter of retired results.

module shift (
    input  logic [31:0] x,
    input  logic [4:0]  y,
    input  logic [1:0]  fn,
    output logic [31:0] z
);

    always_comb begin
        z = '0;
        case (fn)
            2'b00:   z = x << y;
            2'b01:   z = x >> y;
            2'b11:   z = $unsigned($signed(x) >>> y);
            default: z = '0;
        endcase
    end

endmodule

module exu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic [31:0] retired
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wen;
    } entry_t;

    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    entry_t      new_entry;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] retired_q, retired_d;

    logic [1:0]  shift_fn;
    logic [31:0] shift_z;
    logic [31:0] alu_res;
    logic        alu_legal;
    logic        in_fire;
    logic        out_fire;

    always_comb begin
        shift_fn = 2'b10;
        case (in_op)
            4'd2:    shift_fn = 2'b00;
            4'd6:    shift_fn = 2'b01;
            4'd7:    shift_fn = 2'b11;
            default: shift_fn = 2'b10;
        endcase
    end

    shift u_shift (
        .x  (in_src1),
        .y  (in_src2[4:0]),
        .fn (shift_fn),
        .z  (shift_z)
    );

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (in_op)
            4'd0:    alu_res = in_src1 + in_src2;
            4'd1:    alu_res = in_src1 - in_src2;
            4'd2,
            4'd6,
            4'd7:    alu_res = shift_z;
            4'd3:    alu_res = {31'd0, ($signed(in_src1) < $signed(in_src2))};
            4'd4:    alu_res = {31'd0, (in_src1 < in_src2)};
            4'd5:    alu_res = in_src1 ^ in_src2;
            4'd8:    alu_res = in_src1 | in_src2;
            4'd9:    alu_res = in_src1 & in_src2;
            4'd10:   alu_res = in_src2;
            default: begin
                alu_res   = '0;
                alu_legal = 1'b0;
            end
        endcase
    end

    // x0 writes and illegal opcodes are masked on entry so out_wen is a plain flop.
    always_comb begin
        new_entry.pc     = in_pc;
        new_entry.result = alu_res;
        new_entry.rd     = in_rd;
        new_entry.wen    = in_wen && alu_legal && (in_rd != 5'd0);
    end

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        retired_d    = retired_q + {31'd0, out_fire};

        if (out_fire && skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (in_fire && (!main_valid_q || out_fire)) begin
            main_d       = new_entry;
            main_valid_d = 1'b1;
        end else if (in_fire) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            retired_q    <= retired_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_pc     = main_q.pc;
    assign out_result = main_q.result;
    assign out_rd     = main_q.rd;
    assign out_wen    = main_q.wen;
    assign retired    = retired_q;

endmodule

// File: tb/tb_exu_stage.sv
// Randomized and directed bench for exu_stage; a two-deep in-order queue stands in
// for the main/skid pair and a plain-arithmetic ALU computes expected results.

module tb_exu_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_src1, in_src2;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_result, retired;
    logic [4:0]  out_rd;
    logic        out_wen;

    always #5 clk = ~clk;

    exu_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .retired    (retired)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ret_m  = '0;
    logic [31:0] pc_cnt = 32'h0000_1000;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("retired", retired, ret_m);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_result", out_result, q[0].res);
            chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            chk("out_wen", {31'd0, out_wen}, {31'd0, q[0].wen});
        end
    endtask

    // One clock: drive at negedge, advance the model, check at the following negedge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic w,
                       input logic ordy, input logic fl, input logic r);
        exp_t e;
        logic of, inf;
        in_valid  = v;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        in_rd     = rd;
        in_wen    = w;
        in_pc     = pc_cnt;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        e.pc  = pc_cnt;
        e.res = ref_alu(op, a, b);
        e.rd  = rd;
        e.wen = w && (rd != 5'd0) && (op <= 4'd10);
        pc_cnt = pc_cnt + 32'd4;
        of  = (q.size() > 0) && ordy;
        inf = v && (q.size() < 2);
        if (r) begin
            q.delete();
            ret_m = '0;
        end else begin
            if (of) begin
                void'(q.pop_front());
                ret_m = ret_m + 32'd1;
            end
            if (fl) q.delete();
            else if (inf) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        cyc(1'b1, op, a, b, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_op = '0; in_src1 = '0; in_src2 = '0; in_rd = '0; in_wen = 1'b0;
        @(negedge clk);

        cyc(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_wen", {31'd0, out_wen}, 32'd0);

        send(4'd0, 32'd5, 32'd7, 5'd1);
        chk("add_5_7", out_result, 32'd12);
        send(4'd1, 32'd3, 32'd5, 5'd2);
        chk("sub_3_5", out_result, 32'hFFFF_FFFE);
        send(4'd4, 32'd1, 32'hFFFF_FFFF, 5'd3);
        chk("sltu_1_max", out_result, 32'd1);
        idle(1'b1);
        chk("retired_3", retired, 32'd3);

        send(4'd2, 32'd1, 32'd31, 5'd4);
        chk("sll_31", out_result, 32'h8000_0000);
        send(4'd6, 32'h8000_0000, 32'd4, 5'd4);
        chk("srl_4", out_result, 32'h0800_0000);
        send(4'd7, 32'h8000_0000, 32'd4, 5'd4);
        chk("sra_4", out_result, 32'hF800_0000);
        send(4'd7, 32'h8000_0000, 32'h24, 5'd4);
        chk("sra_0x24", out_result, 32'hF800_0000);
        idle(1'b1);

        cyc(1'b1, 4'd0, 32'd100, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'hFF00, 32'h0FF0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_a", out_result, 32'd101);
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        cyc(1'b1, 4'd8, 32'h1, 32'h2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_still_a", out_result, 32'd101);
        cyc(1'b1, 4'd8, 32'h1, 32'h2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_b", out_result, 32'hF0F0);
        cyc(1'b1, 4'd8, 32'h1, 32'h2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_c", out_result, 32'h3);
        idle(1'b1);
        idle(1'b1);

        cyc(1'b1, 4'd0, 32'd1, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 32'd2, 32'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 32'd3, 32'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        idle(1'b1);
        idle(1'b1);

        send(4'd0, 32'd1, 32'd2, 5'd0);
        chk("x0_wen", {31'd0, out_wen}, 32'd0);
        send(4'd13, 32'd9, 32'd9, 5'd3);
        chk("illegal_res", out_result, 32'd0);
        chk("illegal_wen", {31'd0, out_wen}, 32'd0);
        send(4'd10, 32'd0, 32'h1234_5000, 5'd3);
        chk("pass", out_result, 32'h1234_5000);
        send(4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 5'd3);
        chk("slt_edge", out_result, 32'd1);
        send(4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 5'd3);
        chk("sltu_edge", out_result, 32'd0);
        idle(1'b1);

        force dut.retired_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        ret_m = 32'hFFFF_FFFF;
        chk("wrap_pre", retired, 32'hFFFF_FFFF);
        send(4'd0, 32'd1, 32'd1, 5'd1);
        idle(1'b1);
        chk("wrap_zero", retired, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rand_operand(),
                rand_operand(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_stage.md
# exu_stage

Execute stage of the NPC core. It accepts one decoded RV32 integer operation per cycle from the decode unit over a valid/ready handshake and computes the ALU result. Shift operations are computed by the `shift` barrel shifter, which this block instantiates and drives. The result is registered, with a one-entry skid buffer, and handed to the memory/write-back side. The block also provides a pipeline flush and a retired-result counter.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous pipeline kill; empties the stage.
- `in_valid` input 1: decode presents an operation.
- `in_ready` output 1: stage can accept; a function of registered state only.
- `in_pc` input 32: PC of the operation.
- `in_op` input 4: operation code (see Operation).
- `in_src1` input 32: operand 1.
- `in_src2` input 32: operand 2 (register or immediate, already selected).
- `in_rd` input 5: destination register.
- `in_wen` input 1: register write enable.
- `out_valid` output 1: result held for downstream.
- `out_ready` input 1: downstream accepts.
- `out_pc` output 32: PC of the result.
- `out_result` output 32: computed value.
- `out_rd` output 5: destination register.
- `out_wen` output 1: write enable; forced to 0 when `out_rd`==0.
- `retired` output 32: count of output handshakes; wraps modulo 2^32.

## Operation
- Opcodes:
  - 0 ADD src1+src2, mod 2^32.
  - 1 SUB src1−src2, mod 2^32.
  - 2 SLL.
  - 3 SLT: signed less-than, result 1 or 0.
  - 4 SLTU: unsigned less-than, result 1 or 0.
  - 5 XOR.
  - 6 SRL.
  - 7 SRA.
  - 8 OR.
  - 9 AND.
  - 10 PASS: result = src2 (LUI).
  - 11–15: result 0, `wen` forced 0.
- Shifts: the shifter gets x=src1 and y=src2[4:0]; src2[31:5] is ignored. The shifter's fn input is 00 for SLL, 01 for SRL and 11 for SRA. For non-shift opcodes fn is driven to 10, which gives an output of 0.
- Storage: a main register (drives `out_*`) and a skid register. Each has its own valid bit.
- `in_ready` = !skid_valid.
- Fire rules, evaluated each cycle with in_fire = in_valid&&in_ready and out_fire = out_valid&&out_ready:
  - out_fire with skid_valid: main takes the skid contents and skid_valid clears. in_fire cannot occur in this case.
  - in_fire with main empty, or with out_fire: the new result loads main and main_valid is set.
  - in_fire with main valid and no out_fire: the new result loads the skid register and skid_valid is set.
  - out_fire with no in_fire and no skid: main_valid clears.
- Operations always leave in program order. No operation is ever dropped or duplicated except by flush or reset.
- Main contents must stay stable while out_valid && !out_ready.
- `flush`: the next cycle has main_valid=0 and skid_valid=0. An in_fire in the flush cycle is discarded. An out_fire in the flush cycle still counts in `retired`.
- `rst` has priority over `flush`.

## Timing
- Latency: in_fire in cycle N gives out_valid in cycle N+1.
- Sustained throughput is 1 operation per cycle while out_ready=1.
- `in_ready` deasserts one cycle after a stall begins, i.e. when the skid fills. It reasserts the cycle after the out_fire that drains the skid.
- `retired` increments in the cycle after each out_fire.
- Reset values: out_valid=0, in_ready=1, out_pc=0, out_result=0, out_rd=0, out_wen=0, retired=0, skid empty.
- A reset asserted mid-stream discards all held operations.
- No combinational path from in_valid to in_ready, or from out_ready to in_ready.

## Test plan
- Reset, then streaming: assert rst 1 cycle, then send ADD 5+7, SUB 3−5, SLTU 1<0xFFFFFFFF with out_ready=1. Expect out_result 12, 0xFFFFFFFE, 1 on consecutive cycles; retired=3; in_ready stays 1.
- Shifts: SLL 0x1<<31 gives 0x80000000. SRL 0x80000000>>4 gives 0x08000000. SRA 0x80000000>>4 gives 0xF8000000. SRA with src2=0x24 gives a shift of 4, not 36.
- Backpressure:
  - Stream ops A, B, C with out_ready=0 from the cycle after A is accepted.
  - Expect A held stable and B in skid; in_ready=0 while C is presented, and C is not accepted.
  - Raise out_ready: expect A, B, C in order with no loss.
- Flush: with main and skid full, assert flush together with a new in_valid. Next cycle expect out_valid=0, in_ready=1, and the flushed op never appears.
- x0 and illegal ops:
  - ADD with rd=0, wen=1 gives out_wen=0.
  - op 13 gives result 0 and out_wen=0.
  - PASS with src2=0x12345000 gives 0x12345000.
- Signed compare edges and counter wrap:
  - SLT 0x80000000<0x7FFFFFFF gives 1; SLTU of the same operands gives 0.
  - Force `retired`=0xFFFFFFFF, then one out_fire gives 0.
